// File: rtl/sme_sched_pkg.sv
// Shared types for the string-match engine job scheduler.
// States, end-of-job status codes and the result record header.
package sme_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    CLOSE
  } state_t;

  localparam logic [1:0] STATUS_OK  = 2'b00;
  localparam logic [1:0] STATUS_OVF = 2'b01;
  localparam logic [1:0] STATUS_TMO = 2'b10;

  localparam int ID_W = 3;
  localparam int PN_W = 4;

  // Record = {rec_hdr_t, match_addr}; address width is a top-level parameter.
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [PN_W-1:0] pattern_no;
    logic            last;
    logic [1:0]      status;
  } rec_hdr_t;

endpackage

// File: rtl/sme_result_fifo.sv
// Synchronous result FIFO; a push is refused while full even if
// the same cycle pops, so space only opens on the following cycle.
module sme_result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/sme_job_scheduler.sv
// Round-robin job scheduler in front of one string-match engine,
// tagging hits with the owner id and closing each job with an end record.
module sme_job_scheduler
  import sme_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 8191
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_ci,
  output logic [NUM_REQ-1:0] grant,
  output logic               eng_start,
  output logic               eng_ci,
  input  logic               eng_valid,
  input  logic [ADDR_W-1:0]  eng_match_addr,
  input  logic [3:0]         eng_pattern_no,
  input  logic               eng_finish,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2:0]         res_id,
  output logic [3:0]         res_pattern_no,
  output logic [ADDR_W-1:0]  res_match_addr,
  output logic               res_last,
  output logic [1:0]         res_status,
  output logic               busy
);

  localparam int REC_W = $bits(rec_hdr_t) + ADDR_W;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  state_t              state;
  state_t              state_nx;
  logic [2:0]          id;
  logic [2:0]          rr_ptr;
  logic [1:0]          status;
  logic [WD_W-1:0]     wdog;
  logic                tmo;

  logic                pick_ok;
  logic [2:0]          pick_id;
  logic [NUM_REQ-1:0]  pick_oh;
  logic                pick_ci;

  logic                push;
  rec_hdr_t            push_hdr;
  logic [ADDR_W-1:0]   push_addr;
  logic                full;
  logic                empty;
  rec_hdr_t            head_hdr;
  logic [ADDR_W-1:0]   head_addr;

  assign tmo = (wdog == WD_W'(TIMEOUT));

  // Lowest offset from rr_ptr wins; loop runs downward so it is written last.
  always_comb begin
    int idx;
    idx     = 0;
    pick_ok = 1'b0;
    pick_id = '0;
    pick_oh = '0;
    pick_ci = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (req[idx]) begin
        pick_ok      = 1'b1;
        pick_id      = 3'(idx);
        pick_oh      = '0;
        pick_oh[idx] = 1'b1;
        pick_ci      = req_ci[idx];
      end
    end
  end

  always_comb begin
    state_nx  = state;
    push      = 1'b0;
    push_hdr  = '0;
    push_addr = '0;
    unique case (state)
      IDLE:  if (pick_ok) state_nx = START;
      START: state_nx = RUN;
      RUN: begin
        if (eng_valid && !full) begin
          push                = 1'b1;
          push_hdr.id         = id;
          push_hdr.pattern_no = eng_pattern_no;
          push_addr           = eng_match_addr;
        end
        if (eng_finish || tmo) state_nx = CLOSE;
      end
      CLOSE: begin
        if (!full) begin
          push            = 1'b1;
          push_hdr.id     = id;
          push_hdr.last   = 1'b1;
          push_hdr.status = status;
          state_nx        = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      eng_start <= 1'b0;
      eng_ci    <= 1'b0;
      id        <= '0;
      rr_ptr    <= '0;
      status    <= STATUS_OK;
      wdog      <= '0;
    end else begin
      state     <= state_nx;
      grant     <= '0;
      eng_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_ok) begin
            grant  <= pick_oh;
            id     <= pick_id;
            eng_ci <= pick_ci;
            rr_ptr <= (pick_id == 3'(NUM_REQ - 1)) ? 3'd0 : pick_id + 3'd1;
          end
        end
        START: begin
          eng_start <= 1'b1;
          wdog      <= '0;
        end
        RUN: begin
          wdog <= wdog + 1'b1;
          if (eng_valid && full) status[0] <= 1'b1;
          if (!eng_finish && tmo) status[1] <= 1'b1;
        end
        CLOSE: if (!full) status <= STATUS_OK;
        default: ;
      endcase
    end
  end

  sme_result_fifo #(
    .W     (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({push_hdr, push_addr}),
    .pop       (res_ready),
    .pop_data  ({head_hdr, head_addr}),
    .full      (full),
    .empty     (empty),
    .count     ()
  );

  assign res_valid      = !empty;
  assign res_id         = head_hdr.id;
  assign res_pattern_no = head_hdr.pattern_no;
  assign res_match_addr = head_addr;
  assign res_last       = head_hdr.last;
  assign res_status     = head_hdr.status;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_sme_job_scheduler.sv
// Scoreboard bench for sme_job_scheduler: directed jobs push expected
// records into a queue, a negedge monitor checks every accepted record.
module tb_sme_job_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 12;
  localparam int DEPTH   = 8;
  localparam int TMO     = 8191;

  typedef struct {
    logic [2:0]        id;
    logic [3:0]        pn;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic [1:0]        st;
  } rec_t;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_ci;
  logic [NUM_REQ-1:0] grant;
  logic               eng_start;
  logic               eng_ci;
  logic               eng_valid;
  logic [ADDR_W-1:0]  eng_match_addr;
  logic [3:0]         eng_pattern_no;
  logic               eng_finish;
  logic               res_valid;
  logic               res_ready;
  logic [2:0]         res_id;
  logic [3:0]         res_pattern_no;
  logic [ADDR_W-1:0]  res_match_addr;
  logic               res_last;
  logic [1:0]         res_status;
  logic               busy;

  int   checks = 0;
  int   errors = 0;
  rec_t q[$];

  always #5 clk = ~clk;

  sme_job_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_ci         (req_ci),
    .grant          (grant),
    .eng_start      (eng_start),
    .eng_ci         (eng_ci),
    .eng_valid      (eng_valid),
    .eng_match_addr (eng_match_addr),
    .eng_pattern_no (eng_pattern_no),
    .eng_finish     (eng_finish),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_id         (res_id),
    .res_pattern_no (res_pattern_no),
    .res_match_addr (res_match_addr),
    .res_last       (res_last),
    .res_status     (res_status),
    .busy           (busy)
  );

  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record: got id=%0d pn=%0d addr=%h last=%0d st=%0d, want none",
                 res_id, res_pattern_no, res_match_addr, res_last, res_status);
      end else begin
        rec_t e;
        e = q.pop_front();
        if (res_id !== e.id || res_pattern_no !== e.pn || res_match_addr !== e.addr ||
            res_last !== e.last || res_status !== e.st) begin
          errors++;
          $display("FAIL record: got id=%0d pn=%0d addr=%h last=%0d st=%0d, want id=%0d pn=%0d addr=%h last=%0d st=%0d",
                   res_id, res_pattern_no, res_match_addr, res_last, res_status,
                   e.id, e.pn, e.addr, e.last, e.st);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic expect_rec(input int id, input int pn, input int addr,
                            input bit last, input logic [1:0] st);
    rec_t r;
    r.id   = 3'(id);
    r.pn   = 4'(pn);
    r.addr = ADDR_W'(addr);
    r.last = last;
    r.st   = st;
    q.push_back(r);
  endtask

  task automatic wait_grant(output logic [NUM_REQ-1:0] g);
    int n;
    n = 0;
    g = '0;
    while (grant == '0 && n < 20) begin
      cyc();
      n++;
    end
    g = grant;
    if (grant == '0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got none, want a grant within 20 cycles");
    end
  endtask

  task automatic start_job(input int k, input bit ci);
    logic [NUM_REQ-1:0] g;
    req[k]    = 1'b1;
    req_ci[k] = ci;
    wait_grant(g);
    check("grant", 32'(g), 32'(1 << k));
    req[k] = 1'b0;
    cyc();
    check("eng_start", 32'(eng_start), 32'd1);
    check("eng_ci", 32'(eng_ci), 32'(ci));
  endtask

  task automatic hit(input int pn, input int addr, input bit fin);
    eng_valid      = 1'b1;
    eng_pattern_no = 4'(pn);
    eng_match_addr = ADDR_W'(addr);
    eng_finish     = fin;
    cyc();
    eng_valid  = 1'b0;
    eng_finish = 1'b0;
  endtask

  task automatic finish_job();
    eng_finish = 1'b1;
    cyc();
    eng_finish = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || res_valid || busy) && n < 200) begin
      cyc();
      n++;
    end
    check("drain_done", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    logic [NUM_REQ-1:0] g;
    logic [NUM_REQ-1:0] rr_exp [5];
    int n;
    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000;
    rr_exp[4] = 4'b0001;

    reset = 1'b1;
    req = '0;
    req_ci = '0;
    eng_valid = 1'b0;
    eng_match_addr = '0;
    eng_pattern_no = '0;
    eng_finish = 1'b0;
    res_ready = 1'b1;
    cyc();
    cyc();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_eng_ci", 32'(eng_ci), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    cyc();

    // single job, two hits, ok end record
    start_job(0, 1'b1);
    expect_rec(0, 0, 'h010, 0, 2'b00);
    hit(0, 'h010, 1'b0);
    expect_rec(0, 1, 'h1F3, 0, 2'b00);
    hit(1, 'h1F3, 1'b0);
    expect_rec(0, 0, 0, 1, 2'b00);
    finish_job();
    drain();

    // fairness from a fresh reset with all requests held
    do_reset();
    req = '1;
    for (int j = 0; j < 5; j++) begin
      wait_grant(g);
      check("rr_grant", 32'(g), 32'(rr_exp[j]));
      cyc();
      expect_rec($clog2(int'(rr_exp[j])), 0, 0, 1, 2'b00);
      finish_job();
    end
    req = '0;
    drain();

    // overflow: 10 hits into 8 entries, end record waits for one pop
    do_reset();
    res_ready = 1'b0;
    start_job(2, 1'b0);
    for (int j = 0; j < 10; j++) begin
      if (j < DEPTH) expect_rec(2, j, j * 'h11 + 1, 0, 2'b00);
      hit(j, j * 'h11 + 1, 1'b0);
    end
    expect_rec(2, 0, 0, 1, 2'b01);
    finish_job();
    cyc();
    cyc();
    check("ovf_stall_busy", 32'(busy), 32'd1);
    check("ovf_res_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    cyc();
    cyc();
    check("ovf_closed", 32'(busy), 32'd0);
    res_ready = 1'b1;
    drain();

    // timeout: eng_start seen in first RUN cycle (wdog=0), RUN lasts
    // TMO+1 cycles, CLOSE one more, record visible TMO+2 cycles later
    start_job(3, 1'b1);
    expect_rec(3, 0, 0, 1, 2'b10);
    n = 0;
    while (!res_valid && n < TMO + 20) begin
      cyc();
      n++;
    end
    check("tmo_latency", 32'(n), 32'(TMO + 2));
    drain();

    // engine activity in IDLE is ignored; valid with finish is kept
    hit(3, 'h0AA, 1'b1);
    cyc();
    check("idle_ignore_busy", 32'(busy), 32'd0);
    check("idle_ignore_valid", 32'(res_valid), 32'd0);
    start_job(0, 1'b0);
    expect_rec(0, 5, 'h123, 0, 2'b00);
    hit(5, 'h123, 1'b0);
    expect_rec(0, 7, 'h456, 0, 2'b00);
    expect_rec(0, 0, 0, 1, 2'b00);
    hit(7, 'h456, 1'b1);
    drain();

    // reset mid-job with three records queued
    res_ready = 1'b0;
    start_job(1, 1'b0);
    hit(1, 'h001, 1'b0);
    hit(2, 'h002, 1'b0);
    hit(3, 'h003, 1'b0);
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    cyc();
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_grant", 32'(grant), 32'd0);
    reset = 1'b0;
    res_ready = 1'b1;
    req = '1;
    wait_grant(g);
    check("rst_rr_ptr", 32'(g), 32'b0001);
    req = '0;
    cyc();
    expect_rec(0, 0, 0, 1, 2'b00);
    finish_job();
    drain();

    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
